fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and default sizing.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_FULL = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam int          DEF_MEM_WORDS = 128;
  localparam int          DEF_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} pairs; supports push and pop in the same cycle
// when full, and a flush that discards everything.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   din,
  output logic [63:0]   dout,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, next-PC selection, RUN/FULL/HALT control and a
// decoupling buffer toward the decode stage. Instruction memory is external and combinational.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          MEM_WORDS = DEF_MEM_WORDS,
  parameter int          BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        misalign_err
);

  localparam int          CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic          r_misalign;
  logic [CW-1:0] w_count;
  logic [63:0]   w_head;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_redir_tgt;
  logic          w_full;
  logic          w_pop;
  logic          w_fetch;

  function automatic logic in_range(input logic [31:0] a);
    return {1'b0, a} < PC_LIMIT;
  endfunction

  assign w_pc_inc    = r_pc + 32'd4;
  assign w_redir_tgt = {redirect_pc[31:2], 2'b00};
  assign w_full      = (w_count == CW'(BUF_DEPTH));
  assign w_pop       = out_valid && out_ready;
  assign w_fetch     = (r_state != ST_HALT) && !redirect_valid && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= w_redir_tgt;
      r_state <= in_range(w_redir_tgt) ? ST_RUN : ST_HALT;
      if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
    end else if (w_fetch) begin
      r_pc <= w_pc_inc;
      if (!in_range(w_pc_inc))
        r_state <= ST_HALT;
      else if (!w_pop && (w_count == CW'(BUF_DEPTH - 1)))
        r_state <= ST_FULL;
      else if (w_pop)
        r_state <= ST_RUN;
    end else if (w_pop && (r_state == ST_FULL)) begin
      r_state <= ST_RUN;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fetch),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   ({r_pc, imem_inst}),
    .dout  (w_head),
    .count (w_count)
  );

  // Head storage is not reset, so outputs are forced to zero while the buffer is empty.
  assign out_valid    = (w_count != '0);
  assign out_inst     = out_valid ? w_head[31:0]  : 32'd0;
  assign out_pc       = out_valid ? w_head[63:32] : 32'd0;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign imem_addr    = r_pc;
  assign halted       = r_state[1];
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected deliveries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halted;
  logic        misalign_err;

  logic [31:0] mem [128];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign imem_inst = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem[pc[8:2]];
    sb.push_back(e);
  endtask

  // One clock: check any handshake at the falling edge, then advance past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_delivery observed pc=%h expected none", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_inst", out_inst, e.inst);
        chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0] = 32'h0022_1820;
    mem[1] = 32'hAC01_0000;
    mem[2] = 32'h8C24_0000;
    mem[3] = 32'h1021_0001;

    // reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'd4);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // streaming with consumer always ready
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("stream_no_bubble", 32'(out_valid), 32'd1);
      cyc();
    end
    out_ready = 1'b0;
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);
    cyc();
    cyc();
    chk("fill_imem_addr", imem_addr, 32'h18);
    chk("fill_out_valid", 32'(out_valid), 32'd1);

    // reset while the buffer is full
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_imem_addr", imem_addr, 32'd0);
    chk("midrst_out_pc", out_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // backpressure: buffer saturates, PC holds
    for (int i = 0; i < 5; i++) cyc();
    chk("bp_imem_addr", imem_addr, 32'h8);
    chk("bp_out_pc", out_pc, 32'h0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    out_ready = 1'b1;
    cyc();
    chk("bp_resume_addr", imem_addr, 32'hC);
    cyc();
    cyc();

    // redirect while head holds 0xC
    chk("redir_head_pc", out_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    expect_pc(32'h14); expect_pc(32'h18);
    cyc();
    redirect_valid = 1'b0;
    chk("redir_flushed", 32'(out_valid), 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h14);
    cyc();
    chk("redir_tgt_valid", 32'(out_valid), 32'd1);
    chk("redir_tgt_pc", out_pc, 32'h14);
    cyc();
    cyc();
    out_ready = 1'b0;
    chk("redir_sb_empty", 32'(sb.size()), 32'd0);

    // last word, then halt
    redirect_valid = 1'b1;
    redirect_pc = 32'h1FC;
    cyc();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    expect_pc(32'h1FC);
    chk("last_imem_addr", imem_addr, 32'h1FC);
    cyc();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_drain_valid", 32'(out_valid), 32'd1);
    chk("halt_imem_addr", imem_addr, 32'h200);
    cyc();
    chk("halt_empty", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_no_fetch", imem_addr, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    chk("unhalt", 32'(halted), 32'd0);
    chk("unhalt_addr", imem_addr, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4);
    cyc();
    chk("unhalt_valid", 32'(out_valid), 32'd1);
    chk("unhalt_out_pc", out_pc, 32'h0);
    cyc();
    cyc();
    out_ready = 1'b0;

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_set", 32'(misalign_err), 32'd1);
    chk("mis_addr", imem_addr, 32'h4);
    chk("mis_flushed", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    expect_pc(32'h4);
    cyc();
    cyc();
    out_ready = 1'b0;
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    chk("mis_sb_empty", 32'(sb.size()), 32'd0);

    // redirect far out of range
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("oor_no_output", 32'(out_valid), 32'd0);
    chk("oor_addr_hold", imem_addr, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
